// File: rtl/data_mem_mmio_pkg.sv
// Shared constants and types for the data-side memory / MMIO subsystem.
package data_mem_mmio_pkg;

  // MMIO register offsets (word offset taken from Address[4:2])
  localparam logic [2:0] MMIO_UART_DATA   = 3'd0;
  localparam logic [2:0] MMIO_UART_STATUS = 3'd1;
  localparam logic [2:0] MMIO_TIMER       = 3'd2;
  localparam logic [2:0] MMIO_TIMER_CMP   = 3'd3;

  // Address bit that steers an access to the MMIO page instead of RAM
  localparam int MMIO_SEL_BIT = 31;

  // Compare register comes out of reset as far from the counter as possible
  localparam logic [31:0] TIMER_CMP_RST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/data_mem_mmio_if.sv
// CPU load/store port: address, strobes and data in both directions.
interface data_mem_mmio_if;
  logic [31:0] Address;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Write_data;
  logic [31:0] Read_data;

  modport master (output Address, output MemWrite, output MemRead,
                  output Write_data, input Read_data);
  modport slave  (input Address, input MemWrite, input MemRead,
                  input Write_data, output Read_data);
endinterface

// File: rtl/data_mem_mmio_uart_tx_8n1.sv
// 8N1 serial transmitter. One byte per frame, each symbol held CLK_DIV clocks.
//
// state | meaning
// IDLE  | line high, waiting for load
// START | start bit (tx=0)
// DATA  | eight data bits, LSB first
// STOP  | stop bit (tx=1), then back to IDLE
module uart_tx_8n1
  import data_mem_mmio_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  output logic       busy,
  output logic       tx
);

  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

  uart_state_e   r_state, w_state_nxt;
  logic [BW-1:0] r_baud,  w_baud_nxt;
  logic [2:0]    r_bit,   w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_tx,    w_tx_nxt;

  // State and datapath registers; tx is registered so reset forces the line high at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // Next-state logic: baud down-counter expires at zero and advances the symbol
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    case (r_state)
      IDLE: begin
        if (load) begin
          w_state_nxt = START;
          w_baud_nxt  = BAUD_LAST;
          w_bit_nxt   = '0;
          w_shift_nxt = din;
          w_tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (r_baud == '0) begin
          w_state_nxt = DATA;
          w_baud_nxt  = BAUD_LAST;
          w_tx_nxt    = r_shift[0];
          w_shift_nxt = {1'b0, r_shift[7:1]};
        end else begin
          w_baud_nxt = r_baud - 1'b1;
        end
      end
      DATA: begin
        if (r_baud == '0) begin
          w_baud_nxt = BAUD_LAST;
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
            w_bit_nxt   = '0;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 1'b1;
            w_tx_nxt    = r_shift[0];
            w_shift_nxt = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_baud_nxt = r_baud - 1'b1;
        end
      end
      STOP: begin
        if (r_baud == '0) begin
          w_state_nxt = IDLE;
          w_tx_nxt    = 1'b1;
        end else begin
          w_baud_nxt = r_baud - 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  assign busy = (r_state != IDLE);
  assign tx   = r_tx;

endmodule

// File: rtl/data_mem_mmio.sv
// Data-side memory: word RAM plus an MMIO page with a free-running timer and a UART.
// Every access completes in one cycle; reads are combinational and show pre-edge state.
module data_mem_mmio
  import data_mem_mmio_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int CLK_DIV = 16
) (
  input  logic            clk,
  input  logic            rst,
  data_mem_mmio_if.slave  bus,
  output logic            uart_tx,
  output logic            timer_irq
);

  logic [31:0] r_ram [0:(1<<ADDR_W)-1];
  logic [31:0] r_timer;
  logic [31:0] r_cmp;
  logic        r_irq;

  logic              w_mmio;
  logic [2:0]        w_off;
  logic [ADDR_W-1:0] w_word;
  logic              w_ram_we;
  logic              w_uart_load;
  logic              w_timer_we;
  logic              w_cmp_we;
  logic              w_uart_busy;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign w_mmio      = bus.Address[MMIO_SEL_BIT];
  assign w_off       = bus.Address[4:2];
  assign w_word      = bus.Address[ADDR_W+1:2];
  assign w_ram_we    = bus.MemWrite && !w_mmio;
  assign w_uart_load = bus.MemWrite && w_mmio && (w_off == MMIO_UART_DATA);
  assign w_timer_we  = bus.MemWrite && w_mmio && (w_off == MMIO_TIMER);
  assign w_cmp_we    = bus.MemWrite && w_mmio && (w_off == MMIO_TIMER_CMP);

  // Alias bits of the address are intentionally ignored by the decode
  assign w_unused = ^{bus.Address[30:ADDR_W+2], bus.Address[1:0]};

  // RAM write port; contents deliberately have no reset
  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[w_word] <= bus.Write_data;
  end

  // Free-running counter, overridden by a TIMER store on that edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_timer <= '0;
    else if (w_timer_we) r_timer <= bus.Write_data;
    else                 r_timer <= r_timer + 32'd1;
  end

  // Compare register and sticky match flag; a compare store clears and beats a same-edge match
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmp <= TIMER_CMP_RST;
      r_irq <= 1'b0;
    end else if (w_cmp_we) begin
      r_cmp <= bus.Write_data;
      r_irq <= 1'b0;
    end else if (r_timer == r_cmp) begin
      r_irq <= 1'b1;
    end
  end

  // Load data mux; zero whenever MemRead is low
  always_comb begin
    w_rdata = '0;
    if (bus.MemRead) begin
      if (!w_mmio) begin
        w_rdata = r_ram[w_word];
      end else begin
        case (w_off)
          MMIO_UART_STATUS: w_rdata = {31'b0, w_uart_busy};
          MMIO_TIMER:       w_rdata = r_timer;
          MMIO_TIMER_CMP:   w_rdata = r_cmp;
          default:          w_rdata = '0;
        endcase
      end
    end
  end

  assign bus.Read_data = w_rdata;
  assign timer_irq     = r_irq;

  uart_tx_8n1 #(.CLK_DIV(CLK_DIV)) u_uart (
    .clk  (clk),
    .rst  (rst),
    .load (w_uart_load),
    .din  (bus.Write_data[7:0]),
    .busy (w_uart_busy),
    .tx   (uart_tx)
  );

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed + randomized bench for data_mem_mmio against a cycle-indexed reference model.
module tb_data_mem_mmio;

  localparam int ADDR_W  = 8;
  localparam int CLK_DIV = 4;
  localparam int FRAME   = 10 * CLK_DIV;
  localparam int WORDS   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic uart_tx;
  logic timer_irq;

  data_mem_mmio_if bus();

  data_mem_mmio #(.ADDR_W(ADDR_W), .CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .uart_tx   (uart_tx),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_ram   [0:WORDS-1];
  bit          m_valid [0:WORDS-1];
  logic [31:0] m_timer;
  logic [31:0] m_cmp;
  logic        m_irq;
  bit          m_active;
  int          m_k;
  logic [7:0]  m_byte;
  int          e;
  int          n_checks;
  int          n_err;

  function automatic bit m_busy();
    return m_active && ((e - m_k) < FRAME);
  endfunction

  // Line level after edge e: start symbol, eight data symbols LSB first, stop symbol
  function automatic logic m_tx();
    int d;
    if (!m_busy()) return 1'b1;
    d = (e - m_k) / CLK_DIV;
    if (d == 0) return 1'b0;
    if (d <= 8) return m_byte[d-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic rd);
    if (!rd) return 32'h0;
    if (!a[31]) return m_ram[int'(a[ADDR_W+1:2])];
    case (a[4:2])
      3'd1:    return {31'b0, m_busy()};
      3'd2:    return m_timer;
      3'd3:    return m_cmp;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_timer  = 32'h0;
    m_cmp    = 32'hFFFF_FFFF;
    m_irq    = 1'b0;
    m_active = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One CPU cycle: drive, check load data, clock, advance model, check outputs
  task automatic cyc(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] wd);
    int idx;
    bit mmio;
    logic [2:0] off;
    bus.Address    = a;
    bus.MemRead    = rd;
    bus.MemWrite   = wr;
    bus.Write_data = wd;
    idx  = int'(a[ADDR_W+1:2]);
    mmio = a[31];
    off  = a[4:2];
    #1;
    if (!(rd && !mmio && !m_valid[idx])) chk("read_data", bus.Read_data, m_read(a, rd));
    @(posedge clk);
    if (wr && mmio && off == 3'd3) m_irq = 1'b0;
    else if (m_timer == m_cmp)     m_irq = 1'b1;
    if (wr && mmio && off == 3'd0 && !m_busy()) begin
      m_active = 1'b1;
      m_k      = e + 1;
      m_byte   = wd[7:0];
    end
    if (wr && mmio && off == 3'd3) m_cmp = wd;
    m_timer = (wr && mmio && off == 3'd2) ? wd : m_timer + 32'd1;
    if (wr && !mmio) begin
      m_ram[idx]   = wd;
      m_valid[idx] = 1'b1;
    end
    e++;
    #1;
    chk("uart_tx", {31'b0, uart_tx}, {31'b0, m_tx()});
    chk("timer_irq", {31'b0, timer_irq}, {31'b0, m_irq});
  endtask

  localparam logic [31:0] A_UDATA  = 32'h8000_0000;
  localparam logic [31:0] A_STATUS = 32'h8000_0004;
  localparam logic [31:0] A_TIMER  = 32'h8000_0008;
  localparam logic [31:0] A_CMP    = 32'h8000_000C;

  initial begin
    int k1, k2, k3, busy_cnt, d, op;
    logic [9:0]  pat;
    logic [31:0] r, a, wd;
    logic [7:0]  widx;
    logic [2:0]  off;
    logic        rd, wr;

    n_checks = 0;
    n_err    = 0;
    e        = 0;
    pat      = '0;
    busy_cnt = 0;
    bus.Address = '0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.Write_data = '0;
    model_reset();

    // Reset behaviour
    #2 rst = 1'b1;
    #1;
    chk("rst_tx", {31'b0, uart_tx}, 32'd1);
    chk("rst_irq", {31'b0, timer_irq}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_held", {31'b0, uart_tx}, 32'd1);
    chk("rst_irq_held", {31'b0, timer_irq}, 32'd0);
    rst = 1'b0;
    model_reset();
    cyc(A_STATUS, 1'b1, 1'b0, 32'h0);

    // RAM store/load, alias, MemRead low, simultaneous read+write
    cyc(32'h0000_0010, 1'b0, 1'b1, 32'hDEAD_BEEF);
    cyc(32'h0000_0010, 1'b1, 1'b0, 32'h0);
    cyc(32'h0000_0410, 1'b1, 1'b0, 32'h0);
    cyc(32'h0000_0010, 1'b0, 1'b0, 32'h0);
    cyc(32'h0000_0010, 1'b1, 1'b1, 32'h1234_5678);
    cyc(32'h0000_0010, 1'b1, 1'b0, 32'h0);

    // UART frame of 0xA5 with a dropped second write five cycles in
    cyc(A_UDATA, 1'b0, 1'b1, 32'h0000_00A5);
    k1 = e;
    for (int j = 1; j <= 45; j++) begin
      if (j == 5) begin
        cyc(A_UDATA, 1'b1, 1'b1, 32'h0000_003C);
      end else begin
        bus.Address = A_STATUS; bus.MemRead = 1'b1; bus.MemWrite = 1'b0;
        #1;
        if (bus.Read_data === 32'd1) busy_cnt++;
        cyc(A_STATUS, 1'b1, 1'b0, 32'h0);
      end
      d = e - k1;
      if (d < FRAME && (d % CLK_DIV) == CLK_DIV / 2) pat[d / CLK_DIV] = uart_tx;
    end
    chk("uart_pattern", {22'b0, pat}, {22'b0, 10'b11_0100_1010});
    // 40 busy cycles, one of which was spent on the dropped write instead of a status read
    chk("busy_cycles", busy_cnt, 32'd39);

    // Back-to-back: new write in the very cycle busy first reads 0
    cyc(A_UDATA, 1'b0, 1'b1, 32'h0000_0052);
    k2 = e;
    while (e - k2 < FRAME) cyc(A_STATUS, 1'b1, 1'b0, 32'h0);
    cyc(A_UDATA, 1'b0, 1'b1, 32'h0000_00C3);
    k3 = e;
    chk("b2b_start", {31'b0, uart_tx}, 32'd0);

    // Asynchronous reset during data bit 3 of the 0xC3 frame
    while (e - k3 < 17) cyc(A_STATUS, 1'b1, 1'b0, 32'h0);
    bus.MemWrite = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_tx", {31'b0, uart_tx}, 32'd1);
    @(posedge clk);
    e++;
    #1 rst = 1'b0;
    model_reset();
    cyc(A_STATUS, 1'b1, 1'b0, 32'h0);
    cyc(A_UDATA, 1'b0, 1'b1, 32'h0000_0096);
    repeat (FRAME + 2) cyc(A_STATUS, 1'b1, 1'b0, 32'h0);

    // Timer wrap, compare interrupt, clear, clear-wins-over-set
    cyc(A_TIMER, 1'b0, 1'b1, 32'hFFFF_FFFE);
    cyc(A_CMP,   1'b0, 1'b1, 32'hFFFF_FFFF);
    cyc(A_TIMER, 1'b1, 1'b0, 32'h0);
    chk("irq_set", {31'b0, timer_irq}, 32'd1);
    cyc(A_TIMER, 1'b1, 1'b0, 32'h0);
    cyc(A_TIMER, 1'b1, 1'b0, 32'h0);
    chk("irq_sticky", {31'b0, timer_irq}, 32'd1);
    cyc(A_CMP,   1'b0, 1'b1, 32'h8000_0000);
    chk("irq_cleared", {31'b0, timer_irq}, 32'd0);
    cyc(A_TIMER, 1'b0, 1'b1, 32'h0000_0100);
    cyc(A_CMP,   1'b0, 1'b1, 32'h0000_0102);
    cyc(A_TIMER, 1'b1, 1'b0, 32'h0);
    cyc(A_CMP,   1'b1, 1'b1, 32'h0000_0200);
    chk("irq_clear_wins", {31'b0, timer_irq}, 32'd0);

    // Randomized mix of RAM, MMIO, timer and UART traffic
    for (int n = 0; n < 400; n++) begin
      r    = $urandom;
      wd   = $urandom;
      op   = $urandom_range(0, 9);
      widx = 8'($urandom_range(0, 15));
      off  = 3'($urandom_range(0, 7));
      rd   = 1'($urandom_range(0, 1));
      wr   = 1'b0;
      a    = {1'b0, r[30:10], widx, r[1:0]};
      case (op)
        0, 1, 2: wr = 1'b1;
        3, 4:    rd = 1'b1;
        5, 6: begin rd = 1'b1; a = {1'b1, r[30:5], off, r[1:0]}; end
        7: begin wr = 1'b1; a = {1'b1, r[30:5], 3'd0, r[1:0]}; end
        8: begin
          wr = 1'b1;
          if (r[0]) begin
            a  = {1'b1, r[30:5], 3'd3, r[1:0]};
            wd = m_timer + 32'($urandom_range(0, 6));
          end else begin
            a  = {1'b1, r[30:5], 3'd2, r[1:0]};
          end
        end
        default: begin rd = 1'b0; a = r; end
      endcase
      cyc(a, rd, wr, wd);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
